// File: rtl/video_stream_pkg.sv
// Shared video stream definitions for the camera streamer, tracking and display stages.
package video_stream_pkg;
    localparam int DW           = 24;
    localparam int WIDTH        = 640;
    localparam int HEIGHT       = 480;
    localparam int X_W          = 10;
    localparam int Y_W          = 9;
    localparam int CNT_W        = 19;
    localparam int FRAME_PIXELS = WIDTH * HEIGHT;
    localparam int CH_W         = 8;
    localparam int N_CH         = 3;
    localparam logic [DW-1:0] MARK_COLOR = 24'hFF00FF;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction
endpackage

// File: rtl/color_box_tracker_if.sv
// Avalon-ST sink and source beat signals of one video pipeline stage.
interface color_box_tracker_if;
    import video_stream_pkg::*;

    logic [DW-1:0] snk_data;
    logic          snk_sop;
    logic          snk_eop;
    logic          snk_valid;
    logic          snk_ready;
    logic [DW-1:0] src_data;
    logic          src_sop;
    logic          src_eop;
    logic          src_valid;
    logic          src_ready;

    modport master (
        output snk_data, snk_sop, snk_eop, snk_valid, src_ready,
        input  snk_ready, src_data, src_sop, src_eop, src_valid
    );

    modport slave (
        input  snk_data, snk_sop, snk_eop, snk_valid, src_ready,
        output snk_ready, src_data, src_sop, src_eop, src_valid
    );
endinterface

// File: rtl/rgb_window_compare.sv
// Combinational test of whether every colour channel lies inside an inclusive [min, max] window.
module rgb_window_compare
    import video_stream_pkg::*;
(
    input  logic [DW-1:0] i_pixel,
    input  logic [DW-1:0] i_min,
    input  logic [DW-1:0] i_max,
    output logic          o_match
);
    logic [N_CH-1:0] w_ch_ok;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign w_ch_ok[gi] = (i_pixel[gi*CH_W +: CH_W] >= i_min[gi*CH_W +: CH_W]) &&
                                 (i_pixel[gi*CH_W +: CH_W] <= i_max[gi*CH_W +: CH_W]);
        end
    endgenerate

    assign o_match = &w_ch_ok;
endmodule

// File: rtl/color_box_tracker.sv
// Pass-through video stage: recolours in-window pixels and reports the per-frame
// bounding box and match count of those pixels at end of frame.
module color_box_tracker #(
    parameter int                              WIDTH      = video_stream_pkg::WIDTH,
    parameter int                              HEIGHT     = video_stream_pkg::HEIGHT,
    parameter logic [video_stream_pkg::DW-1:0] MARK_COLOR = video_stream_pkg::MARK_COLOR
) (
    input  logic                               clk,
    input  logic                               reset,
    color_box_tracker_if.slave                 bus,
    input  logic [video_stream_pkg::DW-1:0]    thr_min,
    input  logic [video_stream_pkg::DW-1:0]    thr_max,
    input  logic                               highlight_en,
    output logic [video_stream_pkg::X_W-1:0]   box_x_min,
    output logic [video_stream_pkg::X_W-1:0]   box_x_max,
    output logic [video_stream_pkg::Y_W-1:0]   box_y_min,
    output logic [video_stream_pkg::Y_W-1:0]   box_y_max,
    output logic [video_stream_pkg::CNT_W-1:0] match_count,
    output logic                               box_valid,
    output logic                               frame_err,
    output logic                               frame_done
);
    import video_stream_pkg::*;

    typedef enum logic {S_IDLE, S_FRAME} state_t;

    localparam logic [X_W-1:0]   X_LAST    = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(HEIGHT - 1);
    localparam logic [CNT_W-1:0] PIX_TOTAL = CNT_W'(WIDTH * HEIGHT);

    state_t           r_state;
    logic [DW-1:0]    r_src_data;
    logic             r_src_sop;
    logic             r_src_eop;
    logic             r_src_valid;
    logic [DW-1:0]    r_thr_min;
    logic [DW-1:0]    r_thr_max;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic [CNT_W-1:0] r_beats;
    logic [CNT_W-1:0] r_cnt;
    logic [X_W-1:0]   r_acc_x_min;
    logic [X_W-1:0]   r_acc_x_max;
    logic [Y_W-1:0]   r_acc_y_min;
    logic [Y_W-1:0]   r_acc_y_max;
    logic [X_W-1:0]   r_box_x_min;
    logic [X_W-1:0]   r_box_x_max;
    logic [Y_W-1:0]   r_box_y_min;
    logic [Y_W-1:0]   r_box_y_max;
    logic [CNT_W-1:0] r_match_count;
    logic             r_box_valid;
    logic             r_frame_err;
    logic             r_frame_done;

    logic             w_snk_ready;
    logic             w_accept;
    logic             w_track;
    logic [DW-1:0]    w_win_min;
    logic [DW-1:0]    w_win_max;
    logic             w_match;
    logic             w_hit;
    logic [DW-1:0]    w_out_data;
    logic [X_W-1:0]   w_cur_x;
    logic [Y_W-1:0]   w_cur_y;
    logic [CNT_W-1:0] w_base_beats;
    logic [CNT_W-1:0] w_base_cnt;
    logic [X_W-1:0]   w_base_x_min;
    logic [X_W-1:0]   w_base_x_max;
    logic [Y_W-1:0]   w_base_y_min;
    logic [Y_W-1:0]   w_base_y_max;
    logic [X_W-1:0]   w_x_next;
    logic [Y_W-1:0]   w_y_next;
    logic [CNT_W-1:0] w_beats_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [X_W-1:0]   w_x_min_next;
    logic [X_W-1:0]   w_x_max_next;
    logic [Y_W-1:0]   w_y_min_next;
    logic [Y_W-1:0]   w_y_max_next;
    logic             w_box_valid_next;

    // Ready is held low during reset so nothing is accepted into a clearing pipeline.
    assign w_snk_ready = ~reset & (~r_src_valid | bus.src_ready);
    assign w_accept    = bus.snk_valid & w_snk_ready;
    assign w_track     = bus.snk_sop | (r_state == S_FRAME);
    // The SOP pixel is judged against the live thresholds; the rest of the frame uses the latched copy.
    assign w_win_min   = bus.snk_sop ? thr_min : r_thr_min;
    assign w_win_max   = bus.snk_sop ? thr_max : r_thr_max;

    rgb_window_compare u_window (
        .i_pixel (bus.snk_data),
        .i_min   (w_win_min),
        .i_max   (w_win_max),
        .o_match (w_match)
    );

    always_comb begin
        w_hit        = w_match & w_track;
        w_out_data   = (highlight_en & w_hit) ? MARK_COLOR : bus.snk_data;
        // An SOP beat restarts the frame from a fresh accumulator set, whatever state we were in.
        w_cur_x      = bus.snk_sop ? '0 : r_x;
        w_cur_y      = bus.snk_sop ? '0 : r_y;
        w_base_beats = bus.snk_sop ? '0 : r_beats;
        w_base_cnt   = bus.snk_sop ? '0 : r_cnt;
        w_base_x_min = bus.snk_sop ? '1 : r_acc_x_min;
        w_base_x_max = bus.snk_sop ? '0 : r_acc_x_max;
        w_base_y_min = bus.snk_sop ? '1 : r_acc_y_min;
        w_base_y_max = bus.snk_sop ? '0 : r_acc_y_max;

        w_x_next     = (w_cur_x == X_LAST) ? '0 : w_cur_x + X_W'(1);
        w_y_next     = ((w_cur_x == X_LAST) && (w_cur_y != Y_LAST)) ? w_cur_y + Y_W'(1) : w_cur_y;
        w_beats_next = sat_inc(w_base_beats);
        w_cnt_next   = w_hit ? sat_inc(w_base_cnt) : w_base_cnt;
        w_x_min_next = (w_hit && (w_cur_x < w_base_x_min)) ? w_cur_x : w_base_x_min;
        w_x_max_next = (w_hit && (w_cur_x > w_base_x_max)) ? w_cur_x : w_base_x_max;
        w_y_min_next = (w_hit && (w_cur_y < w_base_y_min)) ? w_cur_y : w_base_y_min;
        w_y_max_next = (w_hit && (w_cur_y > w_base_y_max)) ? w_cur_y : w_base_y_max;
        w_box_valid_next = (w_cnt_next != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_src_data    <= '0;
            r_src_sop     <= 1'b0;
            r_src_eop     <= 1'b0;
            r_src_valid   <= 1'b0;
            r_thr_min     <= '0;
            r_thr_max     <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_beats       <= '0;
            r_cnt         <= '0;
            r_acc_x_min   <= '0;
            r_acc_x_max   <= '0;
            r_acc_y_min   <= '0;
            r_acc_y_max   <= '0;
            r_box_x_min   <= '0;
            r_box_x_max   <= '0;
            r_box_y_min   <= '0;
            r_box_y_max   <= '0;
            r_match_count <= '0;
            r_box_valid   <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;

            if (w_accept) begin
                r_src_data  <= w_out_data;
                r_src_sop   <= bus.snk_sop;
                r_src_eop   <= bus.snk_eop;
                r_src_valid <= 1'b1;
            end else if (bus.src_ready) begin
                r_src_valid <= 1'b0;
            end

            if (w_accept && w_track) begin
                if (bus.snk_sop) begin
                    r_thr_min <= thr_min;
                    r_thr_max <= thr_max;
                end
                r_x         <= w_x_next;
                r_y         <= w_y_next;
                r_beats     <= w_beats_next;
                r_cnt       <= w_cnt_next;
                r_acc_x_min <= w_x_min_next;
                r_acc_x_max <= w_x_max_next;
                r_acc_y_min <= w_y_min_next;
                r_acc_y_max <= w_y_max_next;

                if (bus.snk_eop) begin
                    r_box_x_min   <= w_box_valid_next ? w_x_min_next : '0;
                    r_box_x_max   <= w_box_valid_next ? w_x_max_next : '0;
                    r_box_y_min   <= w_box_valid_next ? w_y_min_next : '0;
                    r_box_y_max   <= w_box_valid_next ? w_y_max_next : '0;
                    r_match_count <= w_cnt_next;
                    r_box_valid   <= w_box_valid_next;
                    r_frame_err   <= (w_beats_next != PIX_TOTAL);
                    r_frame_done  <= 1'b1;
                    r_state       <= S_IDLE;
                end else begin
                    r_state       <= S_FRAME;
                end
            end
        end
    end

    assign bus.snk_ready = w_snk_ready;
    assign bus.src_data  = r_src_data;
    assign bus.src_sop   = r_src_sop;
    assign bus.src_eop   = r_src_eop;
    assign bus.src_valid = r_src_valid;

    assign box_x_min   = r_box_x_min;
    assign box_x_max   = r_box_x_max;
    assign box_y_min   = r_box_y_min;
    assign box_y_max   = r_box_y_max;
    assign match_count = r_match_count;
    assign box_valid   = r_box_valid;
    assign frame_err   = r_frame_err;
    assign frame_done  = r_frame_done;
endmodule

// File: tb/tb_color_box_tracker.sv
// Randomised scoreboard bench for color_box_tracker on a reduced 16x12 frame.
module tb_color_box_tracker;
    localparam int          W    = 16;
    localparam int          H    = 12;
    localparam int          NPIX = W * H;
    localparam logic [23:0] MARK = 24'hFF00FF;

    typedef struct {
        logic [23:0] d;
        logic        sop;
        logic        eop;
    } beat_t;

    typedef struct {
        logic [9:0]  xmin;
        logic [9:0]  xmax;
        logic [8:0]  ymin;
        logic [8:0]  ymax;
        logic [18:0] cnt;
        logic        bv;
        logic        err;
        int          cyc;
    } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] thr_min;
    logic [23:0] thr_max;
    logic        highlight_en;
    logic [9:0]  box_x_min;
    logic [9:0]  box_x_max;
    logic [8:0]  box_y_min;
    logic [8:0]  box_y_max;
    logic [18:0] match_count;
    logic        box_valid;
    logic        frame_err;
    logic        frame_done;

    color_box_tracker_if bus();

    color_box_tracker #(.WIDTH(W), .HEIGHT(H), .MARK_COLOR(MARK)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .thr_min      (thr_min),
        .thr_max      (thr_max),
        .highlight_en (highlight_en),
        .box_x_min    (box_x_min),
        .box_x_max    (box_x_max),
        .box_y_min    (box_y_min),
        .box_y_max    (box_y_max),
        .match_count  (match_count),
        .box_valid    (box_valid),
        .frame_err    (frame_err),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    n_checks = 0;
    int    n_pass = 0;
    int    n_frames = 0;
    beat_t q_out[$];
    res_t  q_res[$];
    bit    rand_ready = 1'b0;
    bit    gap_en = 1'b0;
    int    sop_cyc = 0;
    int    last_acc_cyc = 0;

    // Reference model state: a frame is a sequence of pixels indexed from the SOP.
    bit          m_in_frame;
    int          m_idx;
    int          m_cnt;
    int          m_xmin, m_xmax, m_ymin, m_ymax;
    logic [23:0] m_lo, m_hi;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    function automatic bit in_window(input logic [23:0] p, input logic [23:0] lo, input logic [23:0] hi);
        int v, l, h;
        for (int c = 0; c < 3; c++) begin
            v = int'((p >> (8 * c)) & 24'hFF);
            l = int'((lo >> (8 * c)) & 24'hFF);
            h = int'((hi >> (8 * c)) & 24'hFF);
            if (v < l || v > h) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_in_frame = 1'b0;
        m_idx = 0;
        m_cnt = 0;
    endtask

    task automatic model_beat(input logic [23:0] d, input logic sop, input logic eop);
        beat_t b;
        res_t  r;
        bit    hit;
        int    x, y;
        if (sop) begin
            m_in_frame = 1'b1;
            m_idx = 0;
            m_lo = thr_min;
            m_hi = thr_max;
            m_cnt = 0;
            m_xmin = 1023; m_xmax = 0; m_ymin = 511; m_ymax = 0;
            sop_cyc = cyc;
        end
        hit = m_in_frame && in_window(d, m_lo, m_hi);
        b.d = (hit && highlight_en) ? MARK : d;
        b.sop = sop;
        b.eop = eop;
        q_out.push_back(b);
        if (m_in_frame) begin
            x = m_idx % W;
            y = m_idx / W;
            if (y > H - 1) y = H - 1;
            if (hit) begin
                if (m_cnt < 524287) m_cnt++;
                if (x < m_xmin) m_xmin = x;
                if (x > m_xmax) m_xmax = x;
                if (y < m_ymin) m_ymin = y;
                if (y > m_ymax) m_ymax = y;
            end
            m_idx++;
            if (eop) begin
                r.bv   = (m_cnt != 0);
                r.xmin = r.bv ? 10'(m_xmin) : 10'd0;
                r.xmax = r.bv ? 10'(m_xmax) : 10'd0;
                r.ymin = r.bv ? 9'(m_ymin) : 9'd0;
                r.ymax = r.bv ? 9'(m_ymax) : 9'd0;
                r.cnt  = 19'(m_cnt);
                r.err  = (m_idx != NPIX);
                r.cyc  = cyc;
                q_res.push_back(r);
                m_in_frame = 1'b0;
            end
        end
    endtask

    task automatic send_beat(input logic [23:0] d, input logic sop, input logic eop);
        int   guard;
        logic rdy;
        if (gap_en) begin
            while ($urandom_range(0, 1) == 1) begin
                bus.snk_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        bus.snk_data  = d;
        bus.snk_sop   = sop;
        bus.snk_eop   = eop;
        bus.snk_valid = 1'b1;
        guard = 0;
        forever begin
            @(negedge clk);
            rdy = bus.snk_ready;
            @(posedge clk); #1;
            if (rdy) break;
            guard++;
            if (guard > 1000) begin
                check("snk_ready_timeout", 64'd0, 64'd1);
                finish_run();
            end
        end
        last_acc_cyc = cyc;
        model_beat(d, sop, eop);
        bus.snk_valid = 1'b0;
    endtask

    function automatic logic [23:0] gen_pix(input int kind, input int i);
        int          x, y;
        logic [23:0] p;
        logic [7:0]  lo, hi;
        x = i % W;
        y = i / W;
        p = '0;
        case (kind)
            0: p = 24'h000000;
            1: p = (x >= 5 && x <= 9 && y >= 3 && y <= 7) ? 24'hFF0000 : 24'h000000;
            2: begin
                if ($urandom_range(0, 2) == 0) begin
                    for (int c = 0; c < 3; c++) begin
                        lo = thr_min[8*c +: 8];
                        hi = thr_max[8*c +: 8];
                        p[8*c +: 8] = lo + 8'($urandom_range(0, int'(hi - lo)));
                    end
                end else begin
                    p = 24'($urandom());
                end
            end
            default: p = 24'hFF0000;
        endcase
        return p;
    endfunction

    task automatic send_frame(input int kind, input int n, input bit do_sop, input bit do_eop, input int chg_at);
        for (int i = 0; i < n; i++) begin
            if (i == chg_at) begin
                thr_min = 24'h000000;
                thr_max = 24'h000000;
            end
            send_beat(gen_pix(kind, i), do_sop && (i == 0), do_eop && (i == n - 1));
        end
    endtask

    task automatic rand_thr();
        logic [7:0] lo, span;
        for (int c = 0; c < 3; c++) begin
            lo = 8'($urandom_range(0, 160));
            span = 8'($urandom_range(0, 95));
            thr_min[8*c +: 8] = lo;
            thr_max[8*c +: 8] = lo + span;
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        bus.snk_valid = 1'b0;
        while ((q_out.size() != 0 || q_res.size() != 0) && g < 5000) begin
            @(posedge clk); #1;
            g++;
        end
        check("drain_pending", 64'(q_out.size() + q_res.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ctrl"}, {bus.src_valid, bus.snk_ready, frame_done, box_valid, frame_err,
                               bus.src_sop, bus.src_eop, bus.src_data}, 64'd0);
        check({tag, "_results"}, {match_count, box_x_min, box_x_max, box_y_min, box_y_max}, 64'd0);
    endtask

    task automatic check_red_block(input string tag);
        check(tag, {box_x_min, box_x_max, box_y_min, box_y_max, match_count, box_valid, frame_err},
              {10'd5, 10'd9, 9'd3, 9'd7, 19'd25, 1'b1, 1'b0});
    endtask

    // Monitor: compares every delivered beat and every result update against the scoreboard.
    logic        prev_hold = 1'b0;
    logic [26:0] prev_src = '0;
    always @(negedge clk) begin
        beat_t b;
        res_t  r;
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            check("snk_ready_rule", 64'(bus.snk_ready), 64'(!(bus.src_valid && !bus.src_ready)));
            if (prev_hold)
                check("src_hold", {bus.src_valid, bus.src_data, bus.src_sop, bus.src_eop}, 64'(prev_src));
            if (bus.src_valid && bus.src_ready) begin
                if (q_out.size() == 0) begin
                    check("extra_beat", 64'd1, 64'd0);
                end else begin
                    b = q_out.pop_front();
                    check("beat", {bus.src_data, bus.src_sop, bus.src_eop}, {b.d, b.sop, b.eop});
                end
            end
            if (frame_done) begin
                n_frames++;
                if (q_res.size() == 0) begin
                    check("spurious_frame_done", 64'd1, 64'd0);
                end else begin
                    r = q_res.pop_front();
                    check("frame_done_cycle", 64'(cyc), 64'(r.cyc));
                    check("box_x", {box_x_min, box_x_max}, {r.xmin, r.xmax});
                    check("box_y", {box_y_min, box_y_max}, {r.ymin, r.ymax});
                    check("match_count", 64'(match_count), 64'(r.cnt));
                    check("valid_err", {box_valid, frame_err}, {r.bv, r.err});
                end
                $display("frame %0d: count=%0d x=%0d..%0d y=%0d..%0d box_valid=%0b frame_err=%0b",
                         n_frames, match_count, box_x_min, box_x_max, box_y_min, box_y_max,
                         box_valid, frame_err);
            end
            prev_hold = bus.src_valid && !bus.src_ready;
            prev_src = {bus.src_valid, bus.src_data, bus.src_sop, bus.src_eop};
        end
    end

    always @(posedge clk) begin
        #1;
        bus.src_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #2_000_000;
        check("watchdog", 64'd1, 64'd0);
        finish_run();
    end

    initial begin
        int nf0;
        bus.snk_data = '0;
        bus.snk_sop = 1'b0;
        bus.snk_eop = 1'b0;
        bus.snk_valid = 1'b0;
        bus.src_ready = 1'b1;
        thr_min = 24'hC80000;
        thr_max = 24'hFF3232;
        highlight_en = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;
        #1;
        check("ready_after_reset", 64'(bus.snk_ready), 64'd1);

        // Black frame, back-to-back beats
        send_frame(0, NPIX, 1'b1, 1'b1, -1);
        check("throughput", 64'(last_acc_cyc - sop_cyc), 64'(NPIX - 1));
        drain();
        check("black_results", {box_valid, frame_err, match_count}, 64'd0);

        // Red block with highlight
        send_frame(1, NPIX, 1'b1, 1'b1, -1);
        drain();
        check_red_block("red_block");

        // Same frame under backpressure and input gaps, then random frames
        rand_ready = 1'b1;
        gap_en = 1'b1;
        send_frame(1, NPIX, 1'b1, 1'b1, -1);
        drain();
        check_red_block("red_block_bp");
        for (int f = 0; f < 3; f++) begin
            rand_thr();
            highlight_en = 1'($urandom_range(0, 1));
            send_frame(2, NPIX, 1'b1, 1'b1, -1);
        end
        drain();
        thr_min = 24'hC80000;
        thr_max = 24'hFF3232;
        highlight_en = 1'b1;

        // Short frame, full frame, abandoned partial frame, untracked idle beats
        send_frame(2, 50, 1'b1, 1'b1, -1);
        drain();
        check("short_frame_err", 64'(frame_err), 64'd1);
        send_frame(1, NPIX, 1'b1, 1'b1, -1);
        drain();
        check("full_frame_err", 64'(frame_err), 64'd0);
        nf0 = n_frames;
        send_frame(1, 30, 1'b1, 1'b0, -1);
        send_frame(1, NPIX, 1'b1, 1'b1, -1);
        drain();
        check("restart_one_done", 64'(n_frames - nf0), 64'd1);
        check_red_block("restart_results");
        nf0 = n_frames;
        send_frame(3, 5, 1'b0, 1'b0, -1);
        send_beat(24'hFF0000, 1'b0, 1'b1);
        drain();
        check("idle_no_done", 64'(n_frames - nf0), 64'd0);

        // One-pixel frame
        send_beat(24'hFF0000, 1'b1, 1'b1);
        drain();
        check("one_pixel", {box_x_min, box_x_max, box_y_min, box_y_max, match_count, box_valid, frame_err},
              {10'd0, 10'd0, 9'd0, 9'd0, 19'd1, 1'b1, 1'b1});

        // Oversized frame: y stays at the last line
        send_frame(3, NPIX + 40, 1'b1, 1'b1, -1);
        drain();
        check("oversize", {box_y_max, match_count, frame_err}, {9'(H - 1), 19'(NPIX + 40), 1'b1});

        // Reset mid-frame, then a frame whose thresholds change halfway
        send_frame(1, 100, 1'b1, 1'b0, -1);
        bus.snk_valid = 1'b0;
        reset = 1'b1;
        q_out.delete();
        model_reset();
        @(posedge clk); #1;
        check_reset_state("mid_reset");
        reset = 1'b0;
        send_frame(1, NPIX, 1'b1, 1'b1, 50);
        drain();
        check_red_block("thr_shadow");

        finish_run();
    end
endmodule
